serializador_palavra: RTL and testbench
=======================================

# serializador_palavra

- Parallel-to-serial stage that feeds the serial input `X` of the downstream sequence-detector state machine.
- Accepts a `WIDTH`-bit word over a valid/ready handshake and shifts it out on `X`, one bit per `Clock` cycle.
- Bit order is configurable.
- A configurable number of idle (`X=0`) gap cycles separates consecutive words so the detector sees defined inter-word spacing.

## Interface

Parameters:
- `WIDTH`, default 8: data word width, ≥2.
- `MSB_FIRST`, default 1: 1 = bit `WIDTH-1` shifted first; 0 = bit 0 first.
- `GAP`, default 1: idle cycles inserted after each word, 0..15.

Ports:
- `Clock`, input, 1: single clock, rising edge.
- `Reset`, input, 1: asynchronous, active-high.
- `Dado`, input, `WIDTH`: parallel word to send.
- `Valido`, input, 1: `Dado` is valid.
- `Pronto`, output, 1: block can accept a word this cycle.
- `X`, output, 1: serial bit stream to the detector.
- `Ocupado`, output, 1: 1 while in DESLOCA or PAUSA.
- `Ultimo`, output, 1: 1 during the cycle the last bit of a word is on `X`.

## Operation

- Internal state:
  - FSM with states OCIOSO, DESLOCA, PAUSA.
  - `WIDTH`-bit shift register.
  - Bit counter 0..`WIDTH-1`.
  - Gap counter 0..`GAP-1`.
- Acceptance:
  - A word is accepted on a rising edge where `Valido=1` and `Pronto=1`.
  - `Dado` is captured into the shift register on that edge.
  - Later changes on `Dado` do not affect the word in flight.
- OCIOSO:
  - Outputs: `Pronto=1`, `X=0`, `Ocupado=0`, `Ultimo=0`.
  - On acceptance: load word, bit counter←0, go to DESLOCA.
- DESLOCA:
  - `X` = shift-register MSB if `MSB_FIRST=1`, else LSB. `X` is taken directly from a register bit, never from combinational logic.
  - Each cycle the register shifts by one toward the output end and the bit counter increments.
  - `Ultimo=1` when bit counter = `WIDTH-1`.
  - At bit counter = `WIDTH-1`:
    - `GAP>0`: go to PAUSA, gap counter←0. `Pronto=0` throughout DESLOCA.
    - `GAP=0`: `Pronto=1` during the last-bit cycle only. If `Valido=1`, load the new word, bit counter←0 and stay in DESLOCA, giving back-to-back words with no idle bit. Otherwise go to OCIOSO.
- PAUSA:
  - Outputs: `X=0`, `Pronto=0`, `Ocupado=1`.
  - Go to OCIOSO after exactly `GAP` cycles, i.e. when gap counter = `GAP-1`.
- `Valido` without `Pronto`: no effect; the source holds `Dado`/`Valido` until accepted.
- Reset:
  - While `Reset=1`: state OCIOSO, counters 0, shift register 0, `X=0`, `Ocupado=0`, `Ultimo=0`, `Pronto=0`. `Pronto` is gated low during reset.
  - Reset asserted mid-word aborts the word immediately (asynchronously). No remaining bits are sent after release.
  - First acceptance is possible on the first rising edge after `Reset` falls.

## Timing

- Latency: word accepted at edge k; its first bit is on `X` from edge k until edge k+1. Bit i (in send order) is on `X` during cycle k+i.
- `Ultimo` coincides with bit `WIDTH-1` (send order), cycle k+`WIDTH-1`.
- Minimum acceptance period: `WIDTH+GAP+1` cycles for `GAP>0`; `WIDTH` cycles for `GAP=0`.
- All outputs except `Pronto` are functions of registers only. `Pronto` depends on state and bit counter only, never on `Valido`, so there is no combinational loop with the source.

## Test plan

- Reset then idle (`WIDTH=8`, `MSB_FIRST=1`, `GAP=2`): hold `Reset=1` for 3 cycles, release, `Valido=0` → `X=0`, `Ocupado=0`, `Pronto=0` during reset and 1 after.
- Single word: `Dado=8'b1011_0110` accepted at edge k → `X` = 1,0,1,1,0,1,1,0 over cycles k..k+7, `Ultimo=1` only at k+7, `X=0`/`Pronto=0` at k+8 and k+9, `Pronto=1` at k+10.
- LSB first (`MSB_FIRST=0`): same word → `X` = 0,1,1,0,1,1,0,1.
- Back-to-back (`GAP=0`): `Valido` held high with `8'hF0` then `8'h0F` → 16 consecutive bits 1111000000001111, `Pronto=1` only on the two last-bit cycles (plus the initial idle cycle), no idle bit between words.
- Data change after acceptance: change `Dado` to `8'h00` at k+1 → transmitted bits are still those of the captured word.
- Reset mid-word: assert `Reset` at cycle k+3 (asynchronous, between edges) → `X=0`, `Ocupado=0` immediately. After release the block is in OCIOSO and no leftover bits appear.

Source files
------------

// File: rtl/serializador_palavra.sv
// Parallel-to-serial stage feeding the sequence detector input X.
// Takes a word on a valid/ready handshake, shifts it out one bit per clock, then idles for GAP cycles.
module serializador_palavra #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Dado,
  input  logic             Valido,
  output logic             Pronto,
  output logic             X,
  output logic             Ocupado,
  output logic             Ultimo
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam bit            HAS_GAP  = (GAP > 0);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {OCIOSO, DESLOCA, PAUSA} estado_t;

  estado_t          estado_q, estado_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [3:0]       gap_q, gap_d;
  logic [WIDTH-1:0] shifted;
  logic             ultimo_bit;
  logic             aceita;

  // Zeros are shifted in, so the register drains to 0 and X idles low without extra muxing.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {shift_q[WIDTH-2:0], 1'b0};
      assign X       = shift_q[WIDTH-1];
    end else begin : g_lsb
      assign shifted = {1'b0, shift_q[WIDTH-1:1]};
      assign X       = shift_q[0];
    end
  endgenerate

  assign ultimo_bit = (estado_q == DESLOCA) && (bit_q == LAST_BIT);
  assign aceita     = Valido && Pronto;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado_q <= OCIOSO;
      shift_q  <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
    end else begin
      estado_q <= estado_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    Ultimo   = ultimo_bit;
    Ocupado  = (estado_q != OCIOSO);
    // Pronto never looks at Valido, so the source sees no combinational path back.
    Pronto   = !Reset && ((estado_q == OCIOSO) || (!HAS_GAP && ultimo_bit));

    case (estado_q)
      OCIOSO: begin
        if (aceita) begin
          shift_d  = Dado;
          bit_d    = '0;
          estado_d = DESLOCA;
        end
      end
      DESLOCA: begin
        shift_d = shifted;
        bit_d   = bit_q + 1'b1;
        if (ultimo_bit) begin
          bit_d = '0;
          if (HAS_GAP) begin
            estado_d = PAUSA;
            gap_d    = '0;
          end else if (aceita) begin
            shift_d  = Dado;
            estado_d = DESLOCA;
          end else begin
            estado_d = OCIOSO;
          end
        end
      end
      PAUSA: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d    = '0;
          estado_d = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

endmodule

// File: tb/tb_serializador_palavra.sv
// Bench for serializador_palavra: three instances (MSB/GAP=2, LSB/GAP=2, MSB/GAP=0) with
// expected {X,Ultimo,Pronto} records queued by stimulus and popped by a monitor while Ocupado=1.
module tb_serializador_palavra;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] dado_a = '0, dado_b = '0, dado_c = '0;
  logic       val_a = 1'b0, val_b = 1'b0, val_c = 1'b0;
  logic       pr_a, pr_b, pr_c;
  logic       x_a, x_b, x_c;
  logic       oc_a, oc_b, oc_c;
  logic       ul_a, ul_b, ul_c;

  int tests  = 0;
  int failed = 0;

  logic [2:0] q_a[$];
  logic [2:0] q_b[$];
  logic [2:0] q_c[$];

  always #5 Clock = ~Clock;

  serializador_palavra #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2)) dut_a (
    .Clock(Clock), .Reset(Reset), .Dado(dado_a), .Valido(val_a),
    .Pronto(pr_a), .X(x_a), .Ocupado(oc_a), .Ultimo(ul_a));

  serializador_palavra #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(2)) dut_b (
    .Clock(Clock), .Reset(Reset), .Dado(dado_b), .Valido(val_b),
    .Pronto(pr_b), .X(x_b), .Ocupado(oc_b), .Ultimo(ul_b));

  serializador_palavra #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) dut_c (
    .Clock(Clock), .Reset(Reset), .Dado(dado_c), .Valido(val_c),
    .Pronto(pr_c), .X(x_c), .Ocupado(oc_c), .Ultimo(ul_c));

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Bits listed in send order, first element first; last bit carries Ultimo.
  task automatic push_word(input int which, input logic [7:0] bits_in_order,
                           input logic pronto_last, input int gap);
    logic [2:0] r;
    for (int i = 0; i < 8; i++) begin
      r = {bits_in_order[7-i], (i == 7), (i == 7) ? pronto_last : 1'b0};
      if (which == 0) q_a.push_back(r);
      else if (which == 1) q_b.push_back(r);
      else q_c.push_back(r);
    end
    for (int g = 0; g < gap; g++) begin
      if (which == 0) q_a.push_back(3'b000);
      else if (which == 1) q_b.push_back(3'b000);
      else q_c.push_back(3'b000);
    end
  endtask

  always @(negedge Clock) begin
    if (oc_a) begin
      if (q_a.size() == 0) chk("A unexpected output", {5'd0, x_a, ul_a, pr_a}, 8'hEE);
      else chk("A serial {X,Ultimo,Pronto}", {5'd0, x_a, ul_a, pr_a}, {5'd0, q_a.pop_front()});
    end
    if (oc_b) begin
      if (q_b.size() == 0) chk("B unexpected output", {5'd0, x_b, ul_b, pr_b}, 8'hEE);
      else chk("B serial {X,Ultimo,Pronto}", {5'd0, x_b, ul_b, pr_b}, {5'd0, q_b.pop_front()});
    end
    if (oc_c) begin
      if (q_c.size() == 0) chk("C unexpected output", {5'd0, x_c, ul_c, pr_c}, 8'hEE);
      else chk("C serial {X,Ultimo,Pronto}", {5'd0, x_c, ul_c, pr_c}, {5'd0, q_c.pop_front()});
    end
  end

  initial begin
    // Reset held for 3 cycles: everything low, Pronto gated.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("reset {X,Ocupado,Ultimo,Pronto} A", {4'd0, x_a, oc_a, ul_a, pr_a}, 8'h00);
      chk("reset Pronto B/C", {6'd0, pr_b, pr_c}, 8'h00);
    end
    @(posedge Clock); #1 Reset = 1'b0;
    @(negedge Clock);
    chk("idle {X,Ocupado,Ultimo,Pronto} A", {4'd0, x_a, oc_a, ul_a, pr_a}, 8'h01);
    chk("idle Pronto B/C", {6'd0, pr_b, pr_c}, 8'h03);

    // Word B6 on A (MSB first) and B (LSB first); C streams F0 then 0F back-to-back.
    @(posedge Clock); #1;
    val_a = 1'b1; dado_a = 8'b1011_0110;
    val_b = 1'b1; dado_b = 8'b1011_0110;
    val_c = 1'b1; dado_c = 8'hF0;
    push_word(0, 8'b1011_0110, 1'b0, 2);
    push_word(1, 8'b0110_1101, 1'b0, 2);
    push_word(2, 8'b1111_0000, 1'b1, 0);
    push_word(2, 8'b0000_1111, 1'b1, 0);
    @(posedge Clock); #1;            // edge k: accepted
    val_a = 1'b0; val_b = 1'b0;
    @(posedge Clock); #1;            // k+1: source changes data
    dado_a = 8'h00; dado_b = 8'h00; dado_c = 8'h0F;
    @(posedge Clock);
    @(posedge Clock); #1;            // k+3: A offers 5A while busy, held until taken
    val_a = 1'b1; dado_a = 8'h5A;
    push_word(0, 8'b0101_1010, 1'b0, 2);
    repeat (5) @(posedge Clock); #1; // k+8: C has taken 0F
    val_c = 1'b0;
    @(posedge Clock);
    @(posedge Clock);                // k+10: gap over
    @(negedge Clock);
    chk("A Pronto/Ocupado/X at k+10", {5'd0, pr_a, oc_a, x_a}, 8'h04);
    chk("B Pronto/Ocupado/X at k+10", {5'd0, pr_b, oc_b, x_b}, 8'h04);
    @(posedge Clock); #1;            // k+11: 5A accepted
    val_a = 1'b0;
    repeat (12) @(posedge Clock);
    @(negedge Clock);
    chk("C idle after stream {Pronto,Ocupado,X}", {5'd0, pr_c, oc_c, x_c}, 8'h04);
    chk("A idle after 5A {Pronto,Ocupado,X}", {5'd0, pr_a, oc_a, x_a}, 8'h04);
    chk("queues drained", 8'(q_a.size() + q_b.size() + q_c.size()), 8'd0);

    // Reset mid-word on A: three bits go out, then the word is aborted.
    @(posedge Clock); #1;
    val_a = 1'b1; dado_a = 8'hFF;
    for (int i = 0; i < 3; i++) q_a.push_back(3'b100);
    @(posedge Clock); #1;            // edge k
    val_a = 1'b0;
    repeat (3) @(posedge Clock);     // edge k+3
    #2 Reset = 1'b1;
    #1;
    chk("async abort {X,Ocupado,Ultimo,Pronto}", {4'd0, x_a, oc_a, ul_a, pr_a}, 8'h00);
    chk("abort consumed sent bits", 8'(q_a.size()), 8'd0);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      chk("after abort {X,Ocupado,Pronto}", {5'd0, x_a, oc_a, pr_a}, 8'h01);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
